// File: rtl/spi_master_frame_if.sv
// Handshake and SPI wire bundle for spi_master_frame: parallel frame in/out
// plus the four SPI pins.
interface spi_master_frame_if #(
    parameter int unsigned FW = 8
) ();
    logic          start_transaction;
    logic [FW-1:0] data_in;
    logic [FW-1:0] data_out;
    logic          ready;
    logic          busy;
    logic          miso;
    logic          mosi;
    logic          sclk;
    logic          cs;

    modport master (
        input  start_transaction, data_in, miso,
        output data_out, ready, busy, mosi, sclk, cs
    );

    modport slave (
        output start_transaction, data_in, miso,
        input  data_out, ready, busy, mosi, sclk, cs
    );
endinterface

// File: rtl/spi_master_frame.sv
// Multi-word SPI master, MSB first, any CPOL/CPHA mode, SCLK half-period of
// SCLK_HALFPERIOD clk cycles; frame loaded on start, returned with ready.
module spi_master_frame #(
    parameter int unsigned SPI_DATA_WIDTH  = 8,
    parameter int unsigned FRAME_WORDS     = 1,
    parameter int unsigned SCLK_HALFPERIOD = 1,
    parameter bit          CPOL            = 1'b0,
    parameter bit          CPHA            = 1'b0
) (
    input logic                clk,
    input logic                rst,
    spi_master_frame_if.master bus
);
    localparam int unsigned FW = SPI_DATA_WIDTH * FRAME_WORDS;
    localparam int unsigned HW = (SCLK_HALFPERIOD > 1) ? $clog2(SCLK_HALFPERIOD) : 1;
    localparam int unsigned EW = $clog2(2 * FW);

    localparam logic [HW-1:0] H_LAST    = HW'(SCLK_HALFPERIOD - 1);
    localparam logic [EW-1:0] E_LAST    = EW'(2 * FW - 1);
    // Shift edge that must not advance the TX register: the first leading
    // edge for CPHA=1 (re-presents the MSB), the final trailing edge for CPHA=0.
    localparam logic [EW-1:0] E_NOSHIFT = CPHA ? EW'(0) : E_LAST;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_XFER  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [HW-1:0] hp_q, hp_d;
    logic [EW-1:0] edge_q, edge_d;
    logic [FW-1:0] tx_q, tx_d;
    logic [FW-1:0] rx_q, rx_d;
    logic [FW-1:0] data_out_q, data_out_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          cs_q, cs_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;

    // Outputs are registered from the current state, so the pins lag the FSM
    // by one cycle: the first cycle of each XFER half-period produces an SCLK edge.
    always_comb begin
        state_d    = state_q;
        hp_d       = hp_q;
        edge_d     = edge_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_out_d = data_out_q;
        ready_d    = 1'b0;
        busy_d     = 1'b1;
        cs_d       = 1'b0;
        sclk_d     = CPOL;
        mosi_d     = mosi_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                cs_d   = 1'b1;
                if (bus.start_transaction) begin
                    state_d = ST_SETUP;
                    hp_d    = '0;
                    tx_d    = bus.data_in;
                    rx_d    = '0;
                end
            end
            ST_SETUP: begin
                mosi_d = tx_q[FW-1];
                if (hp_q == H_LAST) begin
                    state_d = ST_XFER;
                    hp_d    = '0;
                    edge_d  = '0;
                end else begin
                    hp_d = hp_q + HW'(1);
                end
            end
            ST_XFER: begin
                sclk_d = sclk_q;
                if (hp_q == '0) begin
                    sclk_d = ~sclk_q;
                    if (edge_q[0] == CPHA) begin
                        rx_d = (rx_q << 1) | FW'(bus.miso);
                    end else if (edge_q != E_NOSHIFT) begin
                        tx_d   = tx_q << 1;
                        mosi_d = tx_d[FW-1];
                    end
                end
                if (hp_q == H_LAST) begin
                    hp_d = '0;
                    if (edge_q == E_LAST) begin
                        state_d = ST_HOLD;
                    end else begin
                        edge_d = edge_q + EW'(1);
                    end
                end else begin
                    hp_d = hp_q + HW'(1);
                end
            end
            ST_HOLD: begin
                if (hp_q == H_LAST) begin
                    state_d = ST_DONE;
                    hp_d    = '0;
                end else begin
                    hp_d = hp_q + HW'(1);
                end
            end
            ST_DONE: begin
                cs_d       = 1'b1;
                ready_d    = 1'b1;
                data_out_d = rx_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cs_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hp_q       <= '0;
            edge_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            cs_q       <= 1'b1;
            sclk_q     <= CPOL;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hp_q       <= hp_d;
            edge_q     <= edge_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.cs       = cs_q;
    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;

endmodule
